// File: rtl/fetch_if.sv
// ============================================================================
// Module  : fetch_if
// Purpose : Fetch-stage handshake bundle: decode controls, IM port, IF/ID regs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic        halt;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        IMreadEn;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_pcPlus4;
  logic        IF_ID_valid;
  logic        halted;
  logic        fetchFault;

  modport master (
    input  stall, redirect, redirectTarget, halt, instr,
    output pc, IMreadEn, IF_ID_instr, IF_ID_pcPlus4, IF_ID_valid, halted, fetchFault
  );

  modport slave (
    output stall, redirect, redirectTarget, halt, instr,
    input  pc, IMreadEn, IF_ID_instr, IF_ID_pcPlus4, IF_ID_valid, halted, fetchFault
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Purpose : MIPS instruction fetch with stall, redirect/squash, halt and
//           out-of-range fetch fault, feeding the IF/ID pipeline register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_BYTES = 512
) (
  input  wire logic clk,
  input  wire logic rst,
  fetch_if.master   fetch
);

  localparam logic [31:0] C_IM_LIMIT = 32'(IM_BYTES);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pcp4;
  logic        r_ifid_valid;
  logic        r_halted;
  logic        r_fault;

  logic [31:0] w_pc_next;
  logic [31:0] w_ifid_instr_next;
  logic [31:0] w_ifid_pcp4_next;
  logic        w_ifid_valid_next;
  logic        w_halted_next;
  logic        w_fault_next;
  logic        w_oor;
  logic [31:0] w_pc_plus4;
  logic        w_unused;

  assign w_oor      = (r_pc >= C_IM_LIMIT);
  assign w_pc_plus4 = r_pc + 32'd4;
  // The low target bits are architecturally meaningless and dropped.
  assign w_unused   = &{1'b0, fetch.redirectTarget[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_ifid_instr <= 32'd0;
      r_ifid_pcp4  <= 32'd0;
      r_ifid_valid <= 1'b0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_pc         <= w_pc_next;
      r_ifid_instr <= w_ifid_instr_next;
      r_ifid_pcp4  <= w_ifid_pcp4_next;
      r_ifid_valid <= w_ifid_valid_next;
      r_halted     <= w_halted_next;
      r_fault      <= w_fault_next;
    end
  end

  always_comb begin
    w_next_state      = r_state;
    w_pc_next         = r_pc;
    w_ifid_instr_next = r_ifid_instr;
    w_ifid_pcp4_next  = r_ifid_pcp4;
    w_ifid_valid_next = r_ifid_valid;
    w_halted_next     = r_halted;
    w_fault_next      = r_fault;

    case (r_state)
      S_BOOT: begin
        w_next_state      = S_RUN;
        w_ifid_instr_next = 32'd0;
        w_ifid_pcp4_next  = 32'd0;
        w_ifid_valid_next = 1'b0;
      end
      S_RUN: begin
        if (w_oor || fetch.halt) begin
          w_next_state      = S_HALT;
          w_halted_next     = 1'b1;
          w_fault_next      = w_oor;
          w_ifid_instr_next = 32'd0;
          w_ifid_pcp4_next  = 32'd0;
          w_ifid_valid_next = 1'b0;
        end else if (fetch.stall) begin
          // Hold everything; decode re-issues any pending redirect later.
          w_pc_next = r_pc;
        end else if (fetch.redirect) begin
          w_pc_next         = {fetch.redirectTarget[31:2], 2'b00};
          w_ifid_instr_next = 32'd0;
          w_ifid_pcp4_next  = 32'd0;
          w_ifid_valid_next = 1'b0;
        end else begin
          w_pc_next         = w_pc_plus4;
          w_ifid_instr_next = fetch.instr;
          w_ifid_pcp4_next  = w_pc_plus4;
          w_ifid_valid_next = 1'b1;
        end
      end
      S_HALT: begin
        w_ifid_instr_next = 32'd0;
        w_ifid_pcp4_next  = 32'd0;
        w_ifid_valid_next = 1'b0;
        w_halted_next     = 1'b1;
      end
      default: begin
        w_next_state = S_HALT;
      end
    endcase
  end

  assign fetch.pc            = r_pc;
  assign fetch.IMreadEn      = (r_state == S_RUN) && !w_oor;
  assign fetch.IF_ID_instr   = r_ifid_instr;
  assign fetch.IF_ID_pcPlus4 = r_ifid_pcp4;
  assign fetch.IF_ID_valid   = r_ifid_valid;
  assign fetch.halted        = r_halted;
  assign fetch.fetchFault    = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module  : tb_fetch_stage
// Purpose : Self-checking bench for fetch_stage against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   chks = 0;

  logic [31:0] mem [0:127];

  fetch_if fbus ();

  fetch_stage #(.RESET_PC(32'h0), .IM_BYTES(512)) dut (
    .clk   (clk),
    .rst   (rst),
    .fetch (fbus.master)
  );

  always #5 clk = ~clk;

  // Combinational instruction ROM driven from the DUT's fetch address.
  always_comb begin
    if (fbus.pc < 32'd512) fbus.instr = mem[fbus.pc[8:2]];
    else                   fbus.instr = 32'hDEAD_BEEF;
  end

  // Behavioural model state.
  bit          m_booted;
  bit          m_halted;
  bit          m_fault;
  logic [31:0] m_pc;
  logic [31:0] m_ii;
  logic [31:0] m_p4;
  bit          m_valid;

  function automatic logic [99:0] dut_snap();
    return {fbus.pc, fbus.IMreadEn, fbus.IF_ID_instr, fbus.IF_ID_pcPlus4,
            fbus.IF_ID_valid, fbus.halted, fbus.fetchFault};
  endfunction

  function automatic logic [99:0] exp_snap();
    logic en;
    en = m_booted && !m_halted && (m_pc < 32'd512);
    return {m_pc, en, m_ii, m_p4, m_valid, m_halted, m_fault};
  endfunction

  task automatic model_reset();
    m_booted = 0; m_halted = 0; m_fault = 0;
    m_pc = 32'h0; m_ii = 0; m_p4 = 0; m_valid = 0;
  endtask

  task automatic model_bubble();
    m_ii = 0; m_p4 = 0; m_valid = 0;
  endtask

  task automatic model_step();
    if (!m_booted) begin
      m_booted = 1;
      model_bubble();
    end else if (!m_halted) begin
      if (m_pc >= 32'd512) begin
        m_halted = 1; m_fault = 1; model_bubble();
      end else if (fbus.halt) begin
        m_halted = 1; model_bubble();
      end else if (fbus.stall) begin
        m_pc = m_pc;
      end else if (fbus.redirect) begin
        m_pc = fbus.redirectTarget & 32'hFFFF_FFFC;
        model_bubble();
      end else begin
        m_ii = mem[m_pc[8:2]];
        m_p4 = m_pc + 32'd4;
        m_pc = m_pc + 32'd4;
        m_valid = 1;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fbus.stall = 0; fbus.redirect = 0; fbus.halt = 0; fbus.redirectTarget = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #1;
    chks++;
    if (dut_snap() !== 100'd0) begin
      errs++; $display("FAIL reset_state: got %h want %h", dut_snap(), 100'd0);
    end
    do_reset();
    chks++;
    if (fbus.IMreadEn !== 1'b0 || fbus.pc !== 32'h0) begin
      errs++; $display("FAIL boot_cycle: got en=%b pc=%h want en=0 pc=0", fbus.IMreadEn, fbus.pc);
    end
  endtask

  task automatic test_sequential();
    cycle();
    chks++;
    if (dut_snap() !== exp_snap()) begin
      errs++; $display("FAIL boot_to_run: got %h want %h", dut_snap(), exp_snap());
    end
    cycle();
    chks++;
    if (fbus.IF_ID_instr !== 32'h1111_1111 || fbus.IF_ID_pcPlus4 !== 32'd4 || fbus.IF_ID_valid !== 1'b1) begin
      errs++; $display("FAIL seq_first: got %h/%h/%b want 11111111/4/1", fbus.IF_ID_instr, fbus.IF_ID_pcPlus4, fbus.IF_ID_valid);
    end
    cycle();
    chks++;
    if (fbus.IF_ID_instr !== 32'h2222_2222 || fbus.IF_ID_pcPlus4 !== 32'd8 || fbus.pc !== 32'd8) begin
      errs++; $display("FAIL seq_second: got %h/%h pc=%h want 22222222/8 pc=8", fbus.IF_ID_instr, fbus.IF_ID_pcPlus4, fbus.pc);
    end
  endtask

  task automatic test_stall();
    fbus.stall = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chks++;
      if (fbus.pc !== 32'd8 || fbus.IF_ID_instr !== 32'h2222_2222 || fbus.IF_ID_pcPlus4 !== 32'd8) begin
        errs++; $display("FAIL stall_hold: got pc=%h %h/%h want pc=8 22222222/8", fbus.pc, fbus.IF_ID_instr, fbus.IF_ID_pcPlus4);
      end
    end
    fbus.stall = 0;
    cycle();
    chks++;
    if (dut_snap() !== exp_snap() || fbus.pc !== 32'hC) begin
      errs++; $display("FAIL stall_release: got %h want %h", dut_snap(), exp_snap());
    end
  endtask

  task automatic test_redirect();
    fbus.redirect = 1; fbus.redirectTarget = 32'h0000_0043;
    cycle();
    idle_inputs();
    chks++;
    if (fbus.pc !== 32'h40 || fbus.IF_ID_valid !== 1'b0 || fbus.IF_ID_instr !== 32'd0 || fbus.IF_ID_pcPlus4 !== 32'd0) begin
      errs++; $display("FAIL redirect_squash: got pc=%h v=%b i=%h p=%h want pc=40 bubble", fbus.pc, fbus.IF_ID_valid, fbus.IF_ID_instr, fbus.IF_ID_pcPlus4);
    end
    cycle();
    chks++;
    if (fbus.IF_ID_instr !== mem[16] || fbus.IF_ID_pcPlus4 !== 32'h44) begin
      errs++; $display("FAIL redirect_fetch: got %h/%h want %h/44", fbus.IF_ID_instr, fbus.IF_ID_pcPlus4, mem[16]);
    end
  endtask

  task automatic test_stall_redirect();
    logic [31:0] pc0;
    pc0 = m_pc;
    fbus.stall = 1; fbus.redirect = 1; fbus.redirectTarget = 32'h0000_0082;
    cycle();
    chks++;
    if (fbus.pc !== pc0 || dut_snap() !== exp_snap()) begin
      errs++; $display("FAIL stall_over_redirect: got pc=%h want %h", fbus.pc, pc0);
    end
    fbus.stall = 0;
    cycle();
    idle_inputs();
    chks++;
    if (fbus.pc !== 32'h80 || fbus.IF_ID_valid !== 1'b0) begin
      errs++; $display("FAIL redirect_after_stall: got pc=%h v=%b want pc=80 v=0", fbus.pc, fbus.IF_ID_valid);
    end
  endtask

  task automatic test_halt();
    logic [31:0] pc0;
    pc0 = m_pc;
    fbus.halt = 1; fbus.redirect = 1; fbus.redirectTarget = 32'h0000_0100;
    cycle();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      chks++;
      if (fbus.halted !== 1'b1 || fbus.fetchFault !== 1'b0 || fbus.IMreadEn !== 1'b0 ||
          fbus.pc !== pc0 || fbus.IF_ID_valid !== 1'b0 || fbus.IF_ID_instr !== 32'd0) begin
        errs++; $display("FAIL halt_hold[%0d]: got h=%b f=%b en=%b pc=%h v=%b want h=1 f=0 en=0 pc=%h v=0",
                         i, fbus.halted, fbus.fetchFault, fbus.IMreadEn, fbus.pc, fbus.IF_ID_valid, pc0);
      end
      fbus.stall = 1'(i & 1); fbus.redirect = 1'(i >> 1);
      cycle();
    end
    idle_inputs();
  endtask

  task automatic test_fault_oor();
    do_reset();
    cycle();
    fbus.redirect = 1; fbus.redirectTarget = 32'h0000_01F0;
    cycle();
    idle_inputs();
    repeat (3) cycle();
    chks++;
    if (fbus.pc !== 32'h1FC || fbus.IMreadEn !== 1'b1) begin
      errs++; $display("FAIL last_word: got pc=%h en=%b want pc=1fc en=1", fbus.pc, fbus.IMreadEn);
    end
    cycle();
    chks++;
    if (fbus.pc !== 32'h200 || fbus.IMreadEn !== 1'b0 || fbus.IF_ID_instr !== mem[127] || fbus.IF_ID_pcPlus4 !== 32'h200) begin
      errs++; $display("FAIL oor_fetch: got pc=%h en=%b i=%h want pc=200 en=0 i=%h", fbus.pc, fbus.IMreadEn, fbus.IF_ID_instr, mem[127]);
    end
    cycle();
    chks++;
    if (fbus.halted !== 1'b1 || fbus.fetchFault !== 1'b1 || fbus.pc !== 32'h200 || fbus.IF_ID_valid !== 1'b0) begin
      errs++; $display("FAIL oor_halt: got h=%b f=%b pc=%h v=%b want h=1 f=1 pc=200 v=0", fbus.halted, fbus.fetchFault, fbus.pc, fbus.IF_ID_valid);
    end
    cycle();
    #2;
    rst = 1;
    #1;
    model_reset();
    chks++;
    if (dut_snap() !== 100'd0) begin
      errs++; $display("FAIL async_reset: got %h want %h", dut_snap(), 100'd0);
    end
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      fbus.stall          = ($urandom_range(0, 3) == 0);
      fbus.redirect       = ($urandom_range(0, 4) == 0);
      fbus.redirectTarget = ($urandom_range(0, 143) << 2) | $urandom_range(0, 3);
      fbus.halt           = ($urandom_range(0, 60) == 0);
      cycle();
      chks++;
      if (dut_snap() !== exp_snap()) begin
        errs++; $display("FAIL random[%0d]: got %h want %h", n, dut_snap(), exp_snap());
      end
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0100_0000 + i;
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    idle_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_halt();
    test_fault_oor();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule

`default_nettype wire
